kmp_search_ctrl: RTL and testbench

//  Sequencer for the pattern-search datapath. Drives the pattern ROM and the text ROM address

---
 rtl/kmp_search_ctrl_pkg.sv | 21 ++
 rtl/kmp_search_ctrl_if.sv | 32 +++
 rtl/kmp_search_ctrl_lps_builder.sv | 84 ++++++++
 rtl/kmp_search_ctrl.sv | 148 ++++++++++++++
 tb/tb_kmp_search_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/kmp_search_ctrl_pkg.sv
// kmp_pkg: shared definitions for the KMP search controller.
//   state_t        scan sequencer states, 4-bit encoding (also driven on the debug LEDs)
//   DEF_CHAR_W     default character width
//   DEF_PAT_LEN    default pattern length
//   DEF_TEXT_LEN   default number of text characters scanned
package kmp_pkg;

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      LOAD  = 4'd1,
      BUILD = 4'd2,
      FETCH = 4'd3,
      CMP   = 4'd4,
      DONE  = 4'd5
   } state_t;

   localparam int unsigned DEF_CHAR_W   = 8;
   localparam int unsigned DEF_PAT_LEN  = 5;
   localparam int unsigned DEF_TEXT_LEN = 11064;

endpackage

// File: rtl/kmp_search_ctrl_if.sv
// kmp_search_ctrl_if: board start/status and both sync-ROM buses of the search controller.
//   inicio        start request level
//   pat_addr/data pattern ROM address out, data back one cycle later
//   text_addr/data text ROM address out, data back one cycle later
//   busy, done, instancias, actual_state   status towards the board
// master = controller side, slave = ROM/board side.
interface kmp_search_ctrl_if #(
   parameter int unsigned CHAR_W  = 8,
   parameter int unsigned PAT_AW  = 3,
   parameter int unsigned TEXT_AW = 14,
   parameter int unsigned CNT_W   = 8
);
   logic               inicio;
   logic [PAT_AW-1:0]  pat_addr;
   logic [CHAR_W-1:0]  pat_data;
   logic [TEXT_AW-1:0] text_addr;
   logic [CHAR_W-1:0]  text_data;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   instancias;
   logic [3:0]         actual_state;

   modport master (
      input  inicio, pat_data, text_data,
      output pat_addr, text_addr, busy, done, instancias, actual_state
   );

   modport slave (
      output inicio, pat_data, text_data,
      input  pat_addr, text_addr, busy, done, instancias, actual_state
   );
endinterface

// File: rtl/kmp_search_ctrl_lps_builder.sv
// kmp_lps_builder: pattern register file plus KMP prefix (LPS) table.
//   wr_en/wr_idx/wr_data   pattern character write during LOAD
//   build_start            restarts the table build (i=1, len=0)
//   build_en/build_done    one build step per enabled cycle; done once i reaches PAT_LEN
//   pat_idx -> pat_rd      pattern read port for the scan
//   lps_idx -> lps_rd      LPS read port for the scan fallback
module kmp_lps_builder
   import kmp_pkg::*;
#(
   parameter int unsigned CHAR_W  = DEF_CHAR_W,
   parameter int unsigned PAT_LEN = DEF_PAT_LEN,
   parameter int unsigned PAT_AW  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [PAT_AW-1:0] wr_idx,
   input  logic [CHAR_W-1:0] wr_data,
   input  logic              build_start,
   input  logic              build_en,
   output logic              build_done,
   input  logic [PAT_AW-1:0] pat_idx,
   output logic [CHAR_W-1:0] pat_rd,
   input  logic [PAT_AW-1:0] lps_idx,
   output logic [PAT_AW-1:0] lps_rd
);
   // Full address-space depth keeps every index width exact; entries past PAT_LEN stay 0.
   localparam int unsigned     DEPTH = 1 << PAT_AW;
   localparam logic [PAT_AW:0] I_END = (PAT_AW+1)'(PAT_LEN);
   localparam logic [PAT_AW:0] I_ONE = (PAT_AW+1)'(1);

   logic [CHAR_W-1:0] pat_q [DEPTH];
   logic [CHAR_W-1:0] pat_d [DEPTH];
   logic [PAT_AW-1:0] lps_q [DEPTH];
   logic [PAT_AW-1:0] lps_d [DEPTH];
   logic [PAT_AW:0]   i_q, i_d;
   logic [PAT_AW-1:0] len_q, len_d;
   logic [PAT_AW-1:0] i_idx;

   assign i_idx      = i_q[PAT_AW-1:0];
   assign build_done = (i_q == I_END);
   assign pat_rd     = pat_q[pat_idx];
   assign lps_rd     = lps_q[lps_idx];

   always_comb begin
      pat_d = pat_q;
      lps_d = lps_q;
      i_d   = i_q;
      len_d = len_q;
      if (wr_en) pat_d[wr_idx] = wr_data;
      if (build_start) begin
         i_d   = I_ONE;
         len_d = '0;
      end else if (build_en && !build_done) begin
         if (pat_q[i_idx] == pat_q[len_q]) begin
            lps_d[i_idx] = len_q + 1'b1;
            len_d        = len_q + 1'b1;
            i_d          = i_q + 1'b1;
         end else if (len_q != '0) begin
            // fall back inside the prefix without advancing i
            len_d = lps_q[len_q - 1'b1];
         end else begin
            lps_d[i_idx] = '0;
            i_d          = i_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            pat_q[k] <= '0;
            lps_q[k] <= '0;
         end
         i_q   <= '0;
         len_q <= '0;
      end else begin
         pat_q <= pat_d;
         lps_q <= lps_d;
         i_q   <= i_d;
         len_q <= len_d;
      end
   end
endmodule

// File: rtl/kmp_search_ctrl.sv
// kmp_search_ctrl: KMP search sequencer between the board and the pattern/text sync ROMs.
//   clk, rst   single clock, synchronous active-high reset
//   bus        kmp_search_ctrl_if master: inicio in, ROM addresses out / data in,
//              busy, done pulse, match count instancias, actual_state debug encoding
// Loads the pattern, builds the LPS table, then scans text 0..TEXT_LEN-1 counting
// (overlapping) matches without ever re-reading a text character.
module kmp_search_ctrl
   import kmp_pkg::*;
#(
   parameter int unsigned CHAR_W   = DEF_CHAR_W,
   parameter int unsigned PAT_LEN  = DEF_PAT_LEN,
   parameter int unsigned PAT_AW   = 3,
   parameter int unsigned TEXT_LEN = DEF_TEXT_LEN,
   parameter int unsigned TEXT_AW  = 14,
   parameter int unsigned CNT_W    = 8
) (
   input logic                clk,
   input logic                rst,
   kmp_search_ctrl_if.master  bus
);
   localparam logic [PAT_AW:0]    LD_END   = (PAT_AW+1)'(PAT_LEN);
   localparam logic [PAT_AW-1:0]  PAT_LAST = PAT_AW'(PAT_LEN - 1);
   localparam logic [TEXT_AW-1:0] T_LAST   = TEXT_AW'(TEXT_LEN - 1);

   state_t             state_q, state_d;
   logic [PAT_AW-1:0]  pat_addr_q, pat_addr_d;
   logic [TEXT_AW-1:0] text_addr_q, text_addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PAT_AW-1:0]  j_q, j_d;
   logic [PAT_AW:0]    ld_cnt_q, ld_cnt_d;

   logic              wr_en, build_start, build_en, build_done, match, advance;
   logic [PAT_AW-1:0] wr_idx, lps_idx, lps_rd;
   logic [CHAR_W-1:0] pat_rd;

   kmp_lps_builder #(
      .CHAR_W  (CHAR_W),
      .PAT_LEN (PAT_LEN),
      .PAT_AW  (PAT_AW)
   ) u_lps (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_idx      (wr_idx),
      .wr_data     (bus.pat_data),
      .build_start (build_start),
      .build_en    (build_en),
      .build_done  (build_done),
      .pat_idx     (j_q),
      .pat_rd      (pat_rd),
      .lps_idx     (lps_idx),
      .lps_rd      (lps_rd)
   );

   // One LPS port serves both the full-match restart and the mismatch fallback.
   assign match   = (bus.text_data == pat_rd);
   assign lps_idx = match ? PAT_LAST : j_q - 1'b1;
   // Capture lags the address by one cycle, so LOAD writes entry ld_cnt-1.
   assign wr_idx  = PAT_AW'(ld_cnt_q - 1'b1);

   always_comb begin
      state_d     = state_q;
      pat_addr_d  = pat_addr_q;
      text_addr_d = text_addr_q;
      cnt_d       = cnt_q;
      j_d         = j_q;
      ld_cnt_d    = ld_cnt_q;
      wr_en       = 1'b0;
      build_start = 1'b0;
      build_en    = 1'b0;
      advance     = 1'b0;
      unique case (state_q)
         IDLE: if (bus.inicio) begin
            state_d     = LOAD;
            pat_addr_d  = '0;
            text_addr_d = '0;
            cnt_d       = '0;
            j_d         = '0;
            ld_cnt_d    = '0;
         end
         LOAD: begin
            ld_cnt_d = ld_cnt_q + 1'b1;
            wr_en    = (ld_cnt_q != '0);
            if (pat_addr_q != PAT_LAST) pat_addr_d = pat_addr_q + 1'b1;
            if (ld_cnt_q == LD_END) begin
               state_d     = BUILD;
               build_start = 1'b1;
            end
         end
         BUILD: begin
            build_en = 1'b1;
            if (build_done) state_d = FETCH;
         end
         FETCH: state_d = CMP;
         CMP: begin
            if (match) begin
               advance = 1'b1;
               if (j_q == PAT_LAST) begin
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                  j_d = lps_rd;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else if (j_q != '0) begin
               // address held, same character compared again next cycle
               j_d = lps_rd;
            end else begin
               advance = 1'b1;
            end
            if (advance) begin
               if (text_addr_q == T_LAST) begin
                  state_d = DONE;
               end else begin
                  text_addr_d = text_addr_q + 1'b1;
                  state_d     = FETCH;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pat_addr_q  <= '0;
         text_addr_q <= '0;
         cnt_q       <= '0;
         j_q         <= '0;
         ld_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         pat_addr_q  <= pat_addr_d;
         text_addr_q <= text_addr_d;
         cnt_q       <= cnt_d;
         j_q         <= j_d;
         ld_cnt_q    <= ld_cnt_d;
      end
   end

   assign bus.pat_addr     = pat_addr_q;
   assign bus.text_addr    = text_addr_q;
   assign bus.busy         = (state_q != IDLE) && (state_q != DONE);
   assign bus.done         = (state_q == DONE);
   assign bus.instancias   = cnt_q;
   assign bus.actual_state = state_q;
endmodule

// File: tb/tb_kmp_search_ctrl.sv
// Directed bench: four controller instances with different TEXT_LEN / CNT_W, each fed by
// its own behavioural sync pattern and text ROM.
module tb_kmp_search_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] start;
   always #5 clk = ~clk;

   kmp_search_ctrl_if #(.CHAR_W(8), .PAT_AW(3), .TEXT_AW(14), .CNT_W(8)) bi0 ();
   kmp_search_ctrl_if #(.CHAR_W(8), .PAT_AW(3), .TEXT_AW(14), .CNT_W(8)) bi1 ();
   kmp_search_ctrl_if #(.CHAR_W(8), .PAT_AW(3), .TEXT_AW(14), .CNT_W(8)) bi2 ();
   kmp_search_ctrl_if #(.CHAR_W(8), .PAT_AW(3), .TEXT_AW(14), .CNT_W(2)) bi3 ();

   kmp_search_ctrl #(.CHAR_W(8), .PAT_LEN(5), .PAT_AW(3), .TEXT_LEN(7), .TEXT_AW(14), .CNT_W(8))
      dut0 (.clk(clk), .rst(rst), .bus(bi0.master));
   kmp_search_ctrl #(.CHAR_W(8), .PAT_LEN(5), .PAT_AW(3), .TEXT_LEN(8), .TEXT_AW(14), .CNT_W(8))
      dut1 (.clk(clk), .rst(rst), .bus(bi1.master));
   kmp_search_ctrl #(.CHAR_W(8), .PAT_LEN(5), .PAT_AW(3), .TEXT_LEN(16), .TEXT_AW(14), .CNT_W(8))
      dut2 (.clk(clk), .rst(rst), .bus(bi2.master));
   kmp_search_ctrl #(.CHAR_W(8), .PAT_LEN(5), .PAT_AW(3), .TEXT_LEN(12), .TEXT_AW(14), .CNT_W(2))
      dut3 (.clk(clk), .rst(rst), .bus(bi3.master));

   logic [7:0] pat_rom  [4][8];
   logic [7:0] text_rom [4][16];

   assign bi0.inicio = start[0];
   assign bi1.inicio = start[1];
   assign bi2.inicio = start[2];
   assign bi3.inicio = start[3];

   always @(posedge clk) begin
      bi0.pat_data  <= pat_rom[0][bi0.pat_addr];
      bi0.text_data <= text_rom[0][bi0.text_addr[3:0]];
      bi1.pat_data  <= pat_rom[1][bi1.pat_addr];
      bi1.text_data <= text_rom[1][bi1.text_addr[3:0]];
      bi2.pat_data  <= pat_rom[2][bi2.pat_addr];
      bi2.text_data <= text_rom[2][bi2.text_addr[3:0]];
      bi3.pat_data  <= pat_rom[3][bi3.pat_addr];
      bi3.text_data <= text_rom[3][bi3.text_addr[3:0]];
   end

   logic [3:0]  done_v, busy_v;
   logic [7:0]  cnt_v [4];
   logic [13:0] ta_v  [4];
   logic [3:0]  st_v  [4];
   logic [2:0]  pa_v  [4];

   assign done_v = {bi3.done, bi2.done, bi1.done, bi0.done};
   assign busy_v = {bi3.busy, bi2.busy, bi1.busy, bi0.busy};
   assign cnt_v[0] = bi0.instancias;
   assign cnt_v[1] = bi1.instancias;
   assign cnt_v[2] = bi2.instancias;
   assign cnt_v[3] = {6'd0, bi3.instancias};
   assign ta_v[0] = bi0.text_addr;
   assign ta_v[1] = bi1.text_addr;
   assign ta_v[2] = bi2.text_addr;
   assign ta_v[3] = bi3.text_addr;
   assign st_v[0] = bi0.actual_state;
   assign st_v[1] = bi1.actual_state;
   assign st_v[2] = bi2.actual_state;
   assign st_v[3] = bi3.actual_state;
   assign pa_v[0] = bi0.pat_addr;
   assign pa_v[1] = bi1.pat_addr;
   assign pa_v[2] = bi2.pat_addr;
   assign pa_v[3] = bi3.pat_addr;

   // done-pulse counters and text_addr monotonicity watch on instance 1
   int          done_cnt [4] = '{0, 0, 0, 0};
   logic [13:0] prev_ta1   = '0;
   logic        prev_busy1 = 1'b0;
   logic        mono_bad   = 1'b0;
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (done_v[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
      prev_ta1   <= ta_v[1];
      prev_busy1 <= busy_v[1];
      if (busy_v[1] && prev_busy1 && (ta_v[1] < prev_ta1)) mono_bad <= 1'b1;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int k, input string tag, output int n);
      n = 0;
      while (done_v[k] !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, int'(done_v[k] === 1'b1), 1);
   endtask

   // one full search on instance k; returns count at done and FETCH/done cycle offsets
   task automatic run(input int k, input string tag, output int cnt, output int t_fetch,
                      output int t_done);
      int d0;
      int n;
      d0      = done_cnt[k];
      t_fetch = -1;
      n       = 0;
      start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
      chk({tag, "_busy_load"}, int'(busy_v[k]), 1);
      while (done_v[k] !== 1'b1 && n < 400) begin
         tick();
         n++;
         if (st_v[k] == 4'd3 && t_fetch < 0) t_fetch = n;
      end
      chk({tag, "_done_seen"}, int'(done_v[k] === 1'b1), 1);
      chk({tag, "_busy_at_done"}, int'(busy_v[k]), 0);
      t_done = n;
      cnt    = int'(cnt_v[k]);
      tick();
      tick();
      chk({tag, "_done_pulses"}, done_cnt[k] - d0, 1);
      chk({tag, "_count_held"}, int'(cnt_v[k]), cnt);
   endtask

   string pats [4] = '{"ABABA", "AAAAA", "ABABC", "AAAAA"};
   string txts [4] = '{"ABABABA", "AAAAAAAA", "ZZZZZZZZZZZZZZZZ", "AAAAAAAAAAAA"};
   int    exp_lps [5] = '{0, 0, 1, 2, 3};

   initial begin
      int cnt, tf, td, n, d0;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 8; i++)  pat_rom[k][i]  = 8'h00;
         for (int i = 0; i < 16; i++) text_rom[k][i] = 8'h00;
         for (int i = 0; i < pats[k].len(); i++) pat_rom[k][i]  = pats[k][i];
         for (int i = 0; i < txts[k].len(); i++) text_rom[k][i] = txts[k][i];
      end
      start = '0;
      rst   = 1'b1;
      repeat (3) tick();
      chk("rst_state", int'(st_v[0]), 0);
      chk("rst_pat_addr", int'(pa_v[0]), 0);
      chk("rst_text_addr", int'(ta_v[0]), 0);
      chk("rst_busy", int'(busy_v[0]), 0);
      chk("rst_done", int'(done_v[0]), 0);
      chk("rst_inst", int'(cnt_v[0]), 0);
      rst = 1'b0;
      tick();

      // 1: ABABA in ABABABA
      run(0, "t1", cnt, tf, td);
      chk("t1_count", cnt, 2);
      for (int i = 0; i < 5; i++)
         chk($sformatf("t1_lps%0d", i), int'(dut0.u_lps.lps_q[i]), exp_lps[i]);

      // 2: overlapping AAAAA matches
      run(1, "t2", cnt, tf, td);
      chk("t2_count", cnt, 4);
      chk("t2_addr_monotonic", int'(mono_bad), 0);

      // 3: no match, 2 cycles per char
      run(2, "t3", cnt, tf, td);
      chk("t3_count", cnt, 0);
      chk("t3_fetch_to_done", td - tf, 32);

      // 4: 2-bit counter saturates
      run(3, "t4", cnt, tf, td);
      chk("t4_count_sat", cnt, 3);

      // 5: reset mid-scan
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      n = 0;
      while (ta_v[0] !== 14'd3 && n < 400) begin
         tick();
         n++;
      end
      chk("t5_reached_t3", int'(ta_v[0]), 3);
      rst = 1'b1;
      tick();
      chk("t5_state", int'(st_v[0]), 0);
      chk("t5_pat_addr", int'(pa_v[0]), 0);
      chk("t5_text_addr", int'(ta_v[0]), 0);
      chk("t5_busy", int'(busy_v[0]), 0);
      chk("t5_done", int'(done_v[0]), 0);
      chk("t5_inst", int'(cnt_v[0]), 0);
      rst = 1'b0;
      tick();
      run(0, "t5r", cnt, tf, td);
      chk("t5_restart_count", cnt, 2);

      // 6a: start pulse during CMP is ignored
      d0 = done_cnt[0];
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      n = 0;
      while (st_v[0] !== 4'd4 && n < 400) begin
         tick();
         n++;
      end
      chk("t6_reached_cmp", int'(st_v[0]), 4);
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      wait_done(0, "t6a", n);
      chk("t6a_count", int'(cnt_v[0]), 2);
      repeat (3) tick();
      chk("t6a_stays_idle", int'(st_v[0]), 0);
      chk("t6a_single_done", done_cnt[0] - d0, 1);

      // 6b: start held through DONE restarts
      d0 = done_cnt[0];
      start[0] = 1'b1;
      wait_done(0, "t6b1", n);
      tick();
      chk("t6b_idle_state", int'(st_v[0]), 0);
      chk("t6b_idle_count", int'(cnt_v[0]), 2);
      tick();
      chk("t6b_reload_state", int'(st_v[0]), 1);
      chk("t6b_cleared", int'(cnt_v[0]), 0);
      start[0] = 1'b0;
      wait_done(0, "t6b2", n);
      chk("t6b_recount", int'(cnt_v[0]), 2);
      tick();
      tick();
      chk("t6b_two_dones", done_cnt[0] - d0, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
